// File: rtl/reg_display_driver_pkg.sv
// reg_display_driver_pkg: shared states, segment codes and double-dabble helpers
package reg_display_driver_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, UPDATE} state_t;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [31:0] DISPLAY_MAX = 32'd9999;
  localparam int BCD_ITER = 14;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  // The thousands nibble never exceeds 9, so dropping its carry-out is safe.
  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic bit_in);
    return 16'({add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0]), bit_in});
  endfunction
endpackage

// File: rtl/reg_display_driver_bcd_to_ssd.sv
// bcd_to_ssd: BCD digit to active-low gfedcba seven-segment code
module bcd_to_ssd
  import reg_display_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/reg_display_driver.sv
// reg_display_driver: samples a register, converts it to BCD and drives four seven-segment displays
module reg_display_driver
  import reg_display_driver_pkg::*;
#(
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  output logic [4:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [3:0]  tho,
  output logic [3:0]  hun,
  output logic [3:0]  ten,
  output logic [3:0]  one,
  output logic [6:0]  thossd,
  output logic [6:0]  hunssd,
  output logic [6:0]  tenssd,
  output logic [6:0]  onessd,
  output logic        led_indicator,
  output logic        busy
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic edge_q, edge_d, pend_q, pend_d, ovf_q, ovf_d, led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] addr_q, addr_d;
  logic [13:0] op_q, op_d;
  logic [15:0] bcd_q, bcd_d, dig_q, dig_d;
  logic [3:0] iter_q, iter_d;
  logic [27:0] ssd_q, ssd_d, seg_w;
  logic step, refresh;

  bcd_to_ssd u_tho (.bcd(bcd_q[15:12]), .seg(seg_w[27:21]));
  bcd_to_ssd u_hun (.bcd(bcd_q[11:8]),  .seg(seg_w[20:14]));
  bcd_to_ssd u_ten (.bcd(bcd_q[7:4]),   .seg(seg_w[13:7]));
  bcd_to_ssd u_one (.bcd(bcd_q[3:0]),   .seg(seg_w[6:0]));

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], step_btn};
    edge_d = sync_q[SYNC_STAGES-1];
    step = sync_q[SYNC_STAGES-1] & ~edge_q;
    refresh = cnt_q == CW'(REFRESH_CYCLES - 1);
    cnt_d = refresh ? '0 : cnt_q + CW'(1);
    // A held step is always consumed on the IDLE cycle, so it only survives while busy.
    pend_d = (state_q != IDLE) & (pend_q | step);
    state_d = state_q;
    addr_d = addr_q;
    ovf_d = ovf_q;
    op_d = op_q;
    bcd_d = bcd_q;
    iter_d = iter_q;
    dig_d = dig_q;
    ssd_d = ssd_q;
    led_d = led_q;
    case (state_q)
      IDLE: begin
        addr_d = (step | pend_q) ? addr_q + 5'd1 : addr_q;
        state_d = (step | pend_q | refresh) ? SAMPLE : IDLE;
      end
      SAMPLE: begin
        ovf_d = rf_read_data > DISPLAY_MAX;
        op_d = ovf_d ? 14'(DISPLAY_MAX) : rf_read_data[13:0];
        bcd_d = '0;
        iter_d = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d = dabble_step(bcd_q, op_q[13]);
        op_d = op_q << 1;
        iter_d = iter_q + 4'd1;
        state_d = iter_q == 4'(BCD_ITER - 1) ? UPDATE : CONVERT;
      end
      UPDATE: begin
        dig_d = bcd_q;
        ssd_d = seg_w;
        led_d = ovf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      edge_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      ovf_q <= 1'b0;
      op_q <= '0;
      bcd_q <= '0;
      iter_q <= '0;
      dig_q <= '0;
      ssd_q <= {4{SEG_0}};
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      edge_q <= edge_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      ovf_q <= ovf_d;
      op_q <= op_d;
      bcd_q <= bcd_d;
      iter_q <= iter_d;
      dig_q <= dig_d;
      ssd_q <= ssd_d;
      led_q <= led_d;
    end
  end

  assign rf_read_addr = addr_q;
  assign {tho, hun, ten, one} = dig_q;
  assign {thossd, hunssd, tenssd, onessd} = ssd_q;
  assign led_indicator = led_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/reg_display_driver.md
Name: reg_display_driver

Overview:
- Debug/inspection stage downstream of the register file's multi-purpose read port.
- Selects a register address and samples its 32-bit value. Converts the value to 4 BCD digits with a sequential double-dabble engine, then drives four static seven-segment displays (thousands, hundreds, tens, ones) plus an overflow LED.
- A push-button steps through registers 0..31. Periodic re-sampling tracks values as the CPU runs.

Parameters:
- REFRESH_CYCLES, 5_000_000, clocks between automatic re-samples of the selected register (minimum 20).
- SYNC_STAGES, 2, flip-flop stages in the step-button synchroniser (minimum 2).

Ports:
- clk  in  1  system clock, the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- step_btn  in  1  asynchronous push-button, active-high; advances the register address.
- rf_read_addr  out  5  multi-purpose read address to the register file.
- rf_read_data  in  32  combinational read data from the register file.
- tho, hun, ten, one  out  4 each  BCD digits of the displayed value.
- thossd, hunssd, tenssd, onessd  out  7 each  active-low segments, bit order gfedcba.
- led_indicator  out  1  1 when the sampled value exceeds 9999.
- busy  out  1  1 while in any state other than IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - rf_read_addr=0, all digits=0, all ssd outputs=7'h40 ("0").
  - led_indicator=0, busy=0, state=IDLE.
  - Refresh counter=0, pending-step flag=0, synchroniser flops=0.
- Step input:
  - step_btn passes through SYNC_STAGES flops, then a rising-edge detector.
  - Each detected edge produces one step pulse.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1 in every state and wraps.
  - The wrap cycle produces a refresh pulse.
- FSM states:
  - IDLE: on a step pulse, rf_read_addr increments (31 wraps to 0) and the FSM goes to SAMPLE. Otherwise, on a refresh pulse, the FSM goes to SAMPLE. When step and refresh coincide, one step is applied and one sample taken.
  - SAMPLE: latch rf_read_data into a 32-bit capture register. Saturation: if the value is greater than 9999 (unsigned), the conversion operand is 14'd9999 and the overflow flag is set; otherwise the operand is value[13:0] and the flag is cleared. Clear the 16-bit BCD shift register and set the iteration counter to 0. Go to CONVERT.
  - CONVERT: one double-dabble iteration per cycle, 14 iterations. Each iteration adds 3 to every BCD nibble that is 5 or more, then shifts the operand MSB into the BCD register. After iteration 13, go to UPDATE.
  - UPDATE: load tho/hun/ten/one from BCD[15:12]/[11:8]/[7:4]/[3:0]. Load the ssd outputs from the decoded digits and led_indicator from the overflow flag. Go to IDLE.
- Outputs are registered and change only in UPDATE.
  - Latency is 16 cycles: 1 SAMPLE + 14 CONVERT + 1 UPDATE.
  - Outputs are valid on the clock edge 16 cycles after the edge on which IDLE accepted the trigger.
- Step pulse while busy:
  - Sets the pending flag (further pulses are absorbed; flag depth 1).
  - rf_read_addr does not change mid-conversion.
  - When the FSM enters IDLE with the flag set, the step is processed on that IDLE cycle and the flag is cleared.
- A refresh pulse while busy is dropped.
- rf_read_addr is stable from the SAMPLE cycle through UPDATE.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - BCD values 10-15 are unreachable; if seen they decode to 7F (blank).
- Reset mid-CONVERT: the conversion is abandoned and all reset values apply on the next edge.

Decomposition:
- Shared package holds:
  - State enum: IDLE, SAMPLE, CONVERT, UPDATE.
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - Constants DISPLAY_MAX=9999 and BCD_ITER=14.
- One combinational sub-module, bcd_to_ssd: 4-bit BCD in, 7-bit active-low segments out. Instantiated four times.

Test Plan:
- Reset held 3 cycles, then released with step_btn=0 -> rf_read_addr=0, ssd outputs all 40, led_indicator=0, busy=0.
- REFRESH_CYCLES=20, rf_read_data=1234 -> 16 cycles after the refresh pulse: tho/hun/ten/one=1/2/3/4; ssd=79/24/30/19; led_indicator=0; busy low after UPDATE.
- rf_read_data=32'h0001_0000 (65536) -> digits 9/9/9/9, ssd all 10, led_indicator=1. A following sample of 0 -> digits 0/0/0/0, led_indicator=0.
- Step pulse 32 times in IDLE (spaced >20 cycles) -> rf_read_addr runs 1..31 then 0. Each step triggers exactly one conversion.
- Step pulse 5 cycles into CONVERT, plus a second pulse 2 cycles later -> rf_read_addr unchanged until IDLE, then increments by exactly 1 and a new conversion starts.
- reset asserted during CONVERT iteration 7 with a prior display of 1234 -> next edge: digits 0, ssd 40, rf_read_addr=0, state IDLE, no stale UPDATE afterward.
